led_pattern_driver: RTL and testbench

- Multi-channel LED pattern generator; the parametrised successor to the single-output fixed-rate blinker.
- A shared tick divider drives N independent channels. Each channel is runtime-configurable to OFF, ON, BLINK (programmable period and high time) or ONESHOT (single timed pulse with done flag).
- Sits between the stopwatch control logic and the board LEDs/status outputs.
- Configuration arrives over a valid/ready write port and is applied only on tick boundaries, so it never glitches an output mid-tick.

---
 rtl/led_pattern_pkg.sv | 34 +++
 rtl/led_pattern_driver_tick.sv | 42 ++++
 rtl/led_pattern_driver.sv | 151 +++++++++++++++
 tb/tb_led_pattern_driver.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// Shared types for the multi-channel LED pattern driver.
// Channel timing fields are sized for TIME_WIDTH up to MAX_TIME_WIDTH.
package led_pattern_pkg;

    localparam int MAX_TIME_WIDTH = 16;

    typedef logic [MAX_TIME_WIDTH-1:0] ltime_t;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_e;

    typedef struct packed {
        mode_e  mode;
        ltime_t period;
        ltime_t high;
        ltime_t phase;
    } chan_t;

    localparam chan_t CHAN_RST = '{
        mode:   MODE_OFF,
        period: ltime_t'(1),
        high:   '0,
        phase:  '0
    };

    function automatic int div_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/led_pattern_driver_tick.sv
// Shared tick divider: one-clk pulse every BOARD/TICK_HZ clocks.
// The pulse is registered, so the first one lands DIV clocks after reset.
module tick_generator
    import led_pattern_pkg::*;
#(
    parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int TICK_HZ                     = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV = BOARD_CLOCK_FREQUENCY_IN_HZ / TICK_HZ;
    localparam int CW  = div_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wrap;
    logic          tick_q;

    // Count 0..DIV-1 and flag the wrap.
    always_comb begin
        wrap  = (cnt_q == LAST);
        cnt_d = wrap ? '0 : cnt_q + CW'(1);
    end

    // Divider counter and registered tick pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= wrap;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/led_pattern_driver.sv
// N-channel LED pattern generator (OFF/ON/BLINK/ONESHOT).
// Config writes queue in a one-entry buffer and land on a tick.
module led_pattern_driver
    import led_pattern_pkg::*;
#(
    parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int TICK_HZ                     = 1000,
    parameter int NUM_CHANNELS                = 4,
    parameter int TIME_WIDTH                  = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sync,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] cfg_channel,
    input  logic [1:0]              cfg_mode,
    input  logic [TIME_WIDTH-1:0]   cfg_period,
    input  logic [TIME_WIDTH-1:0]   cfg_high,
    output logic [NUM_CHANNELS-1:0] led,
    output logic [NUM_CHANNELS-1:0] done,
    output logic                    tick
);

    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic                  pend_valid_q, pend_valid_d;
    logic [CH_W-1:0]       pend_ch_q, pend_ch_d;
    mode_e                 pend_mode_q, pend_mode_d;
    logic [TIME_WIDTH-1:0] pend_period_q, pend_period_d;
    logic [TIME_WIDTH-1:0] pend_high_q, pend_high_d;
    logic                  sync_pend_q, sync_pend_d;
    logic                  accept;
    logic                  apply;

    tick_generator #(
        .BOARD_CLOCK_FREQUENCY_IN_HZ(BOARD_CLOCK_FREQUENCY_IN_HZ),
        .TICK_HZ                    (TICK_HZ)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    assign cfg_ready = ~pend_valid_q;
    assign accept    = cfg_valid & cfg_ready;
    assign apply     = tick & pend_valid_q;

    // Pending write buffer and sync request held until the next tick.
    always_comb begin
        pend_valid_d  = pend_valid_q;
        pend_ch_d     = pend_ch_q;
        pend_mode_d   = pend_mode_q;
        pend_period_d = pend_period_q;
        pend_high_d   = pend_high_q;
        sync_pend_d   = tick ? sync : (sync_pend_q | sync);
        if (apply) begin
            pend_valid_d = 1'b0;
        end else if (accept) begin
            pend_valid_d  = 1'b1;
            pend_ch_d     = cfg_channel;
            pend_mode_d   = mode_e'(cfg_mode);
            pend_period_d = cfg_period;
            pend_high_d   = cfg_high;
        end
    end

    // Pending buffer registers; reset drops any queued write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid_q  <= 1'b0;
            pend_ch_q     <= '0;
            pend_mode_q   <= MODE_OFF;
            pend_period_q <= '0;
            pend_high_q   <= '0;
            sync_pend_q   <= 1'b0;
        end else begin
            pend_valid_q  <= pend_valid_d;
            pend_ch_q     <= pend_ch_d;
            pend_mode_q   <= pend_mode_d;
            pend_period_q <= pend_period_d;
            pend_high_q   <= pend_high_d;
            sync_pend_q   <= sync_pend_d;
        end
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        chan_t  ch_q, ch_d;
        logic   led_q, led_d;
        logic   done_q, done_d;
        ltime_t eff;

        // Per-tick channel evaluation; an apply or sync only resets phase.
        always_comb begin
            ch_d   = ch_q;
            led_d  = led_q;
            done_d = 1'b0;
            eff    = (ch_q.period == '0) ? ltime_t'(1) : ch_q.period;
            if (tick) begin
                if (apply && (pend_ch_q == CH_W'(i))) begin
                    ch_d.mode   = pend_mode_q;
                    ch_d.period = ltime_t'(pend_period_q);
                    ch_d.high   = ltime_t'(pend_high_q);
                    ch_d.phase  = '0;
                end else begin
                    unique case (ch_q.mode)
                        MODE_OFF: led_d = 1'b0;
                        MODE_ON:  led_d = 1'b1;
                        MODE_BLINK: begin
                            if (sync_pend_q) begin
                                ch_d.phase = '0;
                            end else begin
                                led_d      = (ch_q.phase < ch_q.high);
                                ch_d.phase = (ch_q.phase == eff - ltime_t'(1))
                                           ? '0 : ch_q.phase + ltime_t'(1);
                            end
                        end
                        MODE_ONESHOT: begin
                            if (ch_q.phase == ch_q.high) begin
                                led_d      = 1'b0;
                                done_d     = 1'b1;
                                ch_d.mode  = MODE_OFF;
                                ch_d.phase = '0;
                            end else begin
                                led_d      = 1'b1;
                                ch_d.phase = ch_q.phase + ltime_t'(1);
                            end
                        end
                    endcase
                end
            end
        end

        // Channel state and registered outputs.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ch_q   <= CHAN_RST;
                led_q  <= 1'b0;
                done_q <= 1'b0;
            end else begin
                ch_q   <= ch_d;
                led_q  <= led_d;
                done_q <= done_d;
            end
        end

        assign led[i]  = led_q;
        assign done[i] = done_q;
    end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Scoreboard bench for led_pattern_driver (DIV=10, 4 channels).
// Expected per-tick outputs are queued, then popped after each tick.
module tb_led_pattern_driver;

    localparam int DIV = 10;
    localparam logic [1:0] M_OFF  = 2'd0;
    localparam logic [1:0] M_ON   = 2'd1;
    localparam logic [1:0] M_BLK  = 2'd2;
    localparam logic [1:0] M_ONE  = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sync = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_channel = '0;
    logic [1:0] cfg_mode = '0;
    logic [7:0] cfg_period = '0;
    logic [7:0] cfg_high = '0;
    logic [3:0] led;
    logic [3:0] done;
    logic       tick;

    int tests_run = 0;
    int failures  = 0;

    typedef struct {
        string      tag;
        logic [3:0] led;
        logic [3:0] done;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    led_pattern_driver #(
        .BOARD_CLOCK_FREQUENCY_IN_HZ(1000),
        .TICK_HZ                    (100),
        .NUM_CHANNELS               (4),
        .TIME_WIDTH                 (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sync       (sync),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_channel(cfg_channel),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .led        (led),
        .done       (done),
        .tick       (tick)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: sim time %0t exceeded", $time);
        $fatal(1);
    end

    task automatic push(input string tag, input logic [3:0] l,
                        input logic [3:0] d);
        exp_t e;
        e.tag  = tag;
        e.led  = l;
        e.done = d;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cfg_valid = 1'b0;
        sync      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic next_tick();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 4 * DIV && !seen; k++) begin
            @(negedge clk);
            if (tick === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            tests_run++;
            failures++;
            $display("FAIL tick_timeout: tick=%b, required a pulse within %0d clk",
                     tick, 4 * DIV);
        end
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [1:0] mode,
                             input logic [7:0] per, input logic [7:0] hi);
        int k;
        cfg_channel = ch;
        cfg_mode    = mode;
        cfg_period  = per;
        cfg_high    = hi;
        cfg_valid   = 1'b1;
        k = 0;
        while (cfg_ready !== 1'b1 && k < 4 * DIV) begin
            @(negedge clk);
            k++;
        end
        if (cfg_ready !== 1'b1) begin
            tests_run++;
            failures++;
            $display("FAIL cfg_timeout: cfg_ready=%b, required 1", cfg_ready);
        end
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            next_tick();
            @(negedge clk);
            tests_run++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_empty: led=%b, required a queued entry", led);
            end else begin
                e = sb_q.pop_front();
                if (led !== e.led || done !== e.done) begin
                    failures++;
                    $display("FAIL %s: led=%b done=%b, required led=%b done=%b",
                             e.tag, led, done, e.led, e.done);
                end
            end
            @(negedge clk);
            tests_run++;
            if (done !== 4'b0000) begin
                failures++;
                $display("FAIL done_width: done=%b, required 0000", done);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        tests_run++;
        if (led !== 4'b0 || done !== 4'b0 || tick !== 1'b0 || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_vals: led=%b done=%b tick=%b rdy=%b, required 0000 0000 0 1",
                     led, done, tick, cfg_ready);
        end
        do_reset();
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            tests_run++;
            if (tick !== (k % DIV == 0) || cfg_ready !== 1'b1 ||
                led !== 4'b0 || done !== 4'b0) begin
                failures++;
                $display("FAIL idle_clk%0d: tick=%b rdy=%b led=%b done=%b, required tick=%b rdy=1 led=0000 done=0000",
                         k, tick, cfg_ready, led, done, (k % DIV == 0));
            end
        end
    endtask

    task automatic test_blink();
        do_reset();
        next_tick();
        cfg_write(2'd0, M_BLK, 8'd4, 8'd1);
        push("blink_apply", 4'b0000, 4'b0);
        for (int t = 0; t < 9; t++)
            push($sformatf("blink_t%0d", t), (t % 4 == 0) ? 4'b0001 : 4'b0000, 4'b0);
        run_ticks(10);
    endtask

    task automatic test_oneshot();
        do_reset();
        next_tick();
        cfg_write(2'd1, M_ONE, 8'd0, 8'd3);
        push("os_apply", 4'b0000, 4'b0);
        push("os_hi1", 4'b0010, 4'b0);
        push("os_hi2", 4'b0010, 4'b0);
        push("os_hi3", 4'b0010, 4'b0);
        push("os_done", 4'b0000, 4'b0010);
        push("os_after", 4'b0000, 4'b0);
        run_ticks(6);
        next_tick();
        cfg_write(2'd1, M_ONE, 8'd0, 8'd0);
        push("os0_apply", 4'b0000, 4'b0);
        push("os0_done", 4'b0000, 4'b0010);
        push("os0_after", 4'b0000, 4'b0);
        run_ticks(3);
    endtask

    task automatic test_rewrite();
        do_reset();
        next_tick();
        cfg_write(2'd1, M_ONE, 8'd0, 8'd3);
        push("rw_apply", 4'b0000, 4'b0);
        push("rw_hi1", 4'b0010, 4'b0);
        run_ticks(2);
        next_tick();
        cfg_write(2'd1, M_ONE, 8'd0, 8'd3);
        push("rw_reapply", 4'b0010, 4'b0);
        push("rw_hi_a", 4'b0010, 4'b0);
        push("rw_hi_b", 4'b0010, 4'b0);
        push("rw_hi_c", 4'b0010, 4'b0);
        push("rw_done", 4'b0000, 4'b0010);
        push("rw_after", 4'b0000, 4'b0);
        run_ticks(6);
    endtask

    task automatic test_blink_edges();
        do_reset();
        next_tick();
        cfg_write(2'd2, M_BLK, 8'd0, 8'd0);
        for (int t = 0; t < 4; t++) push("blk_p0h0", 4'b0000, 4'b0);
        run_ticks(4);
        next_tick();
        cfg_write(2'd2, M_BLK, 8'd2, 8'd5);
        push("blk_p2h5_apply", 4'b0000, 4'b0);
        for (int t = 0; t < 3; t++) push("blk_p2h5", 4'b0100, 4'b0);
        run_ticks(4);
        next_tick();
        cfg_write(2'd3, M_ON, 8'd0, 8'd0);
        push("on_apply", 4'b0100, 4'b0);
        push("on_a", 4'b1100, 4'b0);
        push("on_b", 4'b1100, 4'b0);
        run_ticks(3);
        next_tick();
        cfg_write(2'd3, M_OFF, 8'd0, 8'd0);
        push("off_apply", 4'b1100, 4'b0);
        push("off_a", 4'b0100, 4'b0);
        push("off_b", 4'b0100, 4'b0);
        run_ticks(3);
    endtask

    task automatic test_sync();
        do_reset();
        next_tick();
        cfg_write(2'd0, M_BLK, 8'd4, 8'd2);
        cfg_write(2'd2, M_BLK, 8'd4, 8'd2);
        push("pre_sync0", 4'b0001, 4'b0);
        push("pre_sync1", 4'b0101, 4'b0);
        push("pre_sync2", 4'b0100, 4'b0);
        push("pre_sync3", 4'b0000, 4'b0);
        push("pre_sync4", 4'b0001, 4'b0);
        push("pre_sync5", 4'b0101, 4'b0);
        run_ticks(6);
        sync = 1'b1;
        @(posedge clk);
        #1 sync = 1'b0;
        push("sync_clear", 4'b0101, 4'b0);
        push("sync_p0", 4'b0101, 4'b0);
        push("sync_p1", 4'b0101, 4'b0);
        push("sync_p2", 4'b0000, 4'b0);
        push("sync_p3", 4'b0000, 4'b0);
        push("sync_wrap", 4'b0101, 4'b0);
        run_ticks(6);
    endtask

    task automatic test_back_to_back();
        int stall;
        do_reset();
        next_tick();
        cfg_write(2'd3, M_ON, 8'd0, 8'd0);
        push("b2b_on_apply", 4'b0000, 4'b0);
        push("b2b_on_a", 4'b1000, 4'b0);
        push("b2b_on_b", 4'b1000, 4'b0);
        run_ticks(3);
        next_tick();
        cfg_channel = 2'd1;
        cfg_mode    = M_ON;
        cfg_valid   = 1'b1;
        @(posedge clk);
        #1 cfg_channel = 2'd0;
        stall = 0;
        @(negedge clk);
        while (cfg_ready !== 1'b1 && stall < 4 * DIV) begin
            stall++;
            @(negedge clk);
        end
        tests_run++;
        if (stall != DIV) begin
            failures++;
            $display("FAIL b2b_stall: stall=%0d clk, required %0d", stall, DIV);
        end
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_pending: cfg_ready=%b, required 0", cfg_ready);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (led !== 4'b0 || done !== 4'b0 || tick !== 1'b0 || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_async_rst: led=%b done=%b tick=%b rdy=%b, required 0000 0000 0 1",
                     led, done, tick, cfg_ready);
        end
        @(negedge clk);
        tests_run++;
        if (cfg_ready !== 1'b1 || led !== 4'b0) begin
            failures++;
            $display("FAIL b2b_rst_hold: rdy=%b led=%b, required 1 0000", cfg_ready, led);
        end
        rst = 1'b0;
        for (int t = 0; t < 3; t++) push("b2b_discarded", 4'b0000, 4'b0);
        run_ticks(3);
    endtask

    initial begin
        test_reset();
        test_blink();
        test_oneshot();
        test_rewrite();
        test_blink_edges();
        test_sync();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
